// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes (fetch, load/store) and physical memory port of mem_arbiter.
interface mem_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        if_err;
   logic        ls_req;
   logic        ls_we;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_gnt;
   logic        ls_rvalid;
   logic [31:0] ls_rdata;
   logic        ls_err;
   logic [31:0] pmi_address;
   logic [31:0] pmi_data_in;
   logic        pmi_mem_rd;
   logic        pmi_mem_wr;
   logic [31:0] pmi_data;
   logic        pmi_mfc;
   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, pmi_data, pmi_mfc,
      input  if_gnt, if_rvalid, if_rdata, if_err, ls_gnt, ls_rvalid, ls_rdata, ls_err,
             pmi_address, pmi_data_in, pmi_mem_rd, pmi_mem_wr
   );
   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, pmi_data, pmi_mfc,
      output if_gnt, if_rvalid, if_rdata, if_err, ls_gnt, ls_rvalid, ls_rdata, ls_err,
             pmi_address, pmi_data_in, pmi_mem_rd, pmi_mem_wr
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin fetch/load-store arbiter sequencing one memory port with decode and timeout.
module mem_arbiter #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
   input logic          clk,
   input logic          rst_n,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t           state, state_d;
   logic             last_ls, last_ls_d, owner_ls, owner_ls_d, derr, derr_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             pick_ls, we, bad, done, ok;
   logic [31:0]      addr, rsp_data;
   logic             if_gnt_d, if_rvalid_d, if_err_d, ls_gnt_d, ls_rvalid_d, ls_err_d, rd_d, wr_d;
   logic [31:0]      if_rdata_d, ls_rdata_d, address_d, data_in_d;
   assign pick_ls  = bus.ls_req && !(bus.if_req && last_ls);
   assign addr     = pick_ls ? bus.ls_addr : bus.if_addr;
   assign we       = pick_ls && bus.ls_we;
   assign bad      = addr[1:0] != 2'b00 || addr[31:16] == 16'h0002 || addr[31:29] == 3'b111 ||
                     (addr[31:16] == 16'h0000 && we);
   // a decode error passes through BUSY without strobes so its response lands one cycle after gnt
   assign done     = derr || bus.pmi_mfc || cnt == CNT_W'(TIMEOUT - 1);
   assign ok       = !derr && bus.pmi_mfc;
   assign rsp_data = ok && bus.pmi_mem_rd ? bus.pmi_data : 32'h0;
   always_comb begin
      state_d     = state;
      last_ls_d   = last_ls;
      owner_ls_d  = owner_ls;
      derr_d      = derr;
      cnt_d       = cnt;
      if_gnt_d    = 1'b0;
      ls_gnt_d    = 1'b0;
      if_rvalid_d = 1'b0;
      ls_rvalid_d = 1'b0;
      if_rdata_d  = bus.if_rdata;
      ls_rdata_d  = bus.ls_rdata;
      if_err_d    = bus.if_err;
      ls_err_d    = bus.ls_err;
      address_d   = bus.pmi_address;
      data_in_d   = bus.pmi_data_in;
      rd_d        = bus.pmi_mem_rd;
      wr_d        = bus.pmi_mem_wr;
      case (state)
         IDLE: if (bus.if_req || bus.ls_req) begin
            state_d    = BUSY;
            if_gnt_d   = !pick_ls;
            ls_gnt_d   = pick_ls;
            owner_ls_d = pick_ls;
            last_ls_d  = pick_ls;
            derr_d     = bad;
            cnt_d      = '0;
            address_d  = bad ? bus.pmi_address : addr;
            data_in_d  = bad || !pick_ls ? bus.pmi_data_in : bus.ls_wdata;
            rd_d       = !bad && !we;
            wr_d       = !bad && we;
         end
         BUSY: if (done) begin
            state_d     = RESP;
            rd_d        = 1'b0;
            wr_d        = 1'b0;
            if_rvalid_d = !owner_ls;
            ls_rvalid_d = owner_ls;
            if_rdata_d  = owner_ls ? bus.if_rdata : rsp_data;
            ls_rdata_d  = owner_ls ? rsp_data : bus.ls_rdata;
            if_err_d    = owner_ls ? bus.if_err : !ok;
            ls_err_d    = owner_ls ? !ok : bus.ls_err;
         end else begin
            cnt_d = cnt + CNT_W'(1);
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         last_ls         <= 1'b0;
         owner_ls        <= 1'b0;
         derr            <= 1'b0;
         cnt             <= '0;
         bus.if_gnt      <= 1'b0;
         bus.ls_gnt      <= 1'b0;
         bus.if_rvalid   <= 1'b0;
         bus.ls_rvalid   <= 1'b0;
         bus.if_rdata    <= 32'h0;
         bus.ls_rdata    <= 32'h0;
         bus.if_err      <= 1'b0;
         bus.ls_err      <= 1'b0;
         bus.pmi_address <= 32'h0;
         bus.pmi_data_in <= 32'h0;
         bus.pmi_mem_rd  <= 1'b0;
         bus.pmi_mem_wr  <= 1'b0;
      end else begin
         state           <= state_d;
         last_ls         <= last_ls_d;
         owner_ls        <= owner_ls_d;
         derr            <= derr_d;
         cnt             <= cnt_d;
         bus.if_gnt      <= if_gnt_d;
         bus.ls_gnt      <= ls_gnt_d;
         bus.if_rvalid   <= if_rvalid_d;
         bus.ls_rvalid   <= ls_rvalid_d;
         bus.if_rdata    <= if_rdata_d;
         bus.ls_rdata    <= ls_rdata_d;
         bus.if_err      <= if_err_d;
         bus.ls_err      <= ls_err_d;
         bus.pmi_address <= address_d;
         bus.pmi_data_in <= data_in_d;
         bus.pmi_mem_rd  <= rd_d;
         bus.pmi_mem_wr  <= wr_d;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, randomized traffic against a transaction-level model, reset/alternation sequence.
module tb_mem_arbiter;
   localparam int TO    = 16;
   localparam int NEVER = 1000;
   typedef struct {
      bit          ls;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mem;
      int          dly;
      bit          err;
      logic [31:0] rdata;
      int          lat;
      int          rd;
      int          wr;
   } vec_t;
   typedef struct {
      bit          v;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } pend_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          checks = 0;
   int          failures = 0;
   int          mfc_dly = 0;
   bit          mfc_noise = 1'b0;
   logic [31:0] rd_word = 32'h0;
   int          rd_cyc = 0;
   int          wr_cyc = 0;
   int          run = 0;
   bit          m_last_ls;
   vec_t        vecs[14];
   pend_t       pend[2];
   mem_arbiter_if bus();
   mem_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   assign bus.pmi_data = rd_word;
   // memory model: mfc after mfc_dly strobe cycles; random mfc noise while no strobe is up
   always @(negedge clk) begin
      if (bus.pmi_mem_rd || bus.pmi_mem_wr) begin
         run         <= run + 1;
         rd_cyc      <= rd_cyc + int'(bus.pmi_mem_rd);
         wr_cyc      <= wr_cyc + int'(bus.pmi_mem_wr);
         bus.pmi_mfc <= run + 1 > mfc_dly;
      end else begin
         run         <= 0;
         bus.pmi_mfc <= mfc_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end
   task automatic step();
      @(negedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask
   task automatic chk_reset(input string name);
      chk({name, "_ctl"}, {bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid, bus.if_err, bus.ls_err,
                           bus.pmi_mem_rd, bus.pmi_mem_wr}, 0);
      chk({name, "_data"}, bus.pmi_address | bus.pmi_data_in | bus.if_rdata | bus.ls_rdata, 0);
   endtask
   function automatic bit exp_err(input logic [31:0] a, input bit w);
      if (a % 4 != 0) return 1'b1;
      if (a < 32'h0001_0000) return w;
      if (a < 32'h0002_0000) return 1'b0;
      if (a < 32'h0003_0000) return 1'b1;
      return a >= 32'hE000_0000;
   endfunction
   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      case ($urandom_range(0, 4))
         0: a = {16'h0000, 16'($urandom)};
         1: a = {16'h0001, 16'($urandom)};
         2: a = {16'h0002, 16'($urandom)};
         3: a = $urandom_range(32'h0003_0000, 32'hDFFF_FFFF);
         default: a = {3'b111, 29'($urandom)};
      endcase
      if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
      return a;
   endfunction
   function automatic pend_t new_req(input bit p);
      pend_t t;
      t.v     = 1'b1;
      t.we    = p && $urandom_range(0, 1) == 1;
      t.addr  = rand_addr();
      t.wdata = $urandom;
      return t;
   endfunction
   task automatic run_vec(input int k, input vec_t v);
      int w, r0, w0;
      rd_word = v.mem;
      mfc_dly = v.dly;
      r0 = rd_cyc;
      w0 = wr_cyc;
      if (v.ls) begin
         bus.ls_req   = 1'b1;
         bus.ls_we    = v.we;
         bus.ls_addr  = v.addr;
         bus.ls_wdata = v.wdata;
      end else begin
         bus.if_req  = 1'b1;
         bus.if_addr = v.addr;
      end
      w = 0;
      do begin step(); w++; end while (!(bus.if_gnt || bus.ls_gnt) && w < 6);
      chk($sformatf("v%0d gnt_wait", k), w, 1);
      chk($sformatf("v%0d gnt_port", k), {bus.ls_gnt, bus.if_gnt}, v.ls ? 2'b10 : 2'b01);
      bus.if_req = 1'b0;
      bus.ls_req = 1'b0;
      if (!v.err) chk($sformatf("v%0d pmi_address", k), bus.pmi_address, v.addr);
      if (!v.err && v.ls) chk($sformatf("v%0d pmi_data_in", k), bus.pmi_data_in, v.wdata);
      w = 0;
      do begin step(); w++; end while (!(bus.if_rvalid || bus.ls_rvalid) && w < 40);
      chk($sformatf("v%0d rsp_latency", k), w, v.lat);
      chk($sformatf("v%0d rvalid_port", k), {bus.ls_rvalid, bus.if_rvalid}, v.ls ? 2'b10 : 2'b01);
      chk($sformatf("v%0d rdata", k), v.ls ? bus.ls_rdata : bus.if_rdata, v.rdata);
      chk($sformatf("v%0d err", k), v.ls ? bus.ls_err : bus.if_err, v.err);
      chk($sformatf("v%0d rd_cycles", k), rd_cyc - r0, v.rd);
      chk($sformatf("v%0d wr_cycles", k), wr_cyc - w0, v.wr);
      step();
      chk($sformatf("v%0d rvalid_pulse", k), {bus.ls_rvalid, bus.if_rvalid}, 0);
   endtask
   initial begin
      int gw, w;
      bit g[$];
      bit r[$];
      vecs[0]  = '{0, 0, 32'h0000_0010, 32'h0,         32'hDEADBEEF, 0,     0, 32'hDEADBEEF, 1,  1,  0};
      vecs[1]  = '{1, 1, 32'h0003_0000, 32'h1234_5678, 32'hFFFF_FFFF, 0,    0, 32'h0,        1,  0,  1};
      vecs[2]  = '{1, 1, 32'h0000_0100, 32'h0000_0001, 32'h1111_1111, 0,    1, 32'h0,        1,  0,  0};
      vecs[3]  = '{1, 0, 32'h0002_0000, 32'h0,         32'h2222_2222, 0,    1, 32'h0,        1,  0,  0};
      vecs[4]  = '{0, 0, 32'hE000_0000, 32'h0,         32'h3333_3333, 0,    1, 32'h0,        1,  0,  0};
      vecs[5]  = '{1, 0, 32'h0003_0002, 32'h0,         32'h4444_4444, 0,    1, 32'h0,        1,  0,  0};
      vecs[6]  = '{1, 0, 32'h0003_0040, 32'h0,         32'h5555_5555, NEVER, 1, 32'h0,       TO, TO, 0};
      vecs[7]  = '{1, 0, 32'h0001_0004, 32'h0,         32'hCAFE_F00D, 2,    0, 32'hCAFE_F00D, 3,  3,  0};
      vecs[8]  = '{0, 0, 32'h0000_FFFC, 32'h0,         32'h0102_0304, 1,    0, 32'h0102_0304, 2,  2,  0};
      vecs[9]  = '{1, 0, 32'hDFFF_FFFC, 32'h0,         32'h55AA_55AA, 0,    0, 32'h55AA_55AA, 1,  1,  0};
      vecs[10] = '{1, 1, 32'h0001_FFFC, 32'hA5A5_A5A5, 32'h0BAD_0BAD, 3,    0, 32'h0,        4,  0,  4};
      vecs[11] = '{1, 0, 32'h0002_FFFC, 32'h0,         32'h7777_7777, 0,    1, 32'h0,        1,  0,  0};
      vecs[12] = '{0, 0, 32'h0001_0000, 32'h0,         32'h8888_0001, 0,    0, 32'h8888_0001, 1,  1,  0};
      vecs[13] = '{1, 0, 32'hFFFF_FFFC, 32'h0,         32'h9999_9999, 1,    1, 32'h0,        1,  0,  0};
      bus.if_req   = 1'b0;
      bus.if_addr  = 32'h0;
      bus.ls_req   = 1'b0;
      bus.ls_we    = 1'b0;
      bus.ls_addr  = 32'h0;
      bus.ls_wdata = 32'h0;
      foreach (pend[p]) pend[p].v = 1'b0;
      repeat (3) step();
      chk_reset("reset");
      rst_n = 1'b1;
      step();
      foreach (vecs[k]) begin
         run_vec(k, vecs[k]);
         m_last_ls = vecs[k].ls;
      end
      gw = 1;
      mfc_noise = 1'b1;
      for (int i = 0; i < 200 || pend[0].v || pend[1].v; i++) begin
         int r0, w0, d, lat;
         bit act, ew, e, tmo, we;
         logic [31:0] er;
         if (i < 200) begin
            for (int p = 0; p < 2; p++) if (!pend[p].v && $urandom_range(0, 1) == 1) pend[p] = new_req(p[0]);
            if (!pend[0].v && !pend[1].v) begin
               act = 1'($urandom_range(0, 1));
               pend[act] = new_req(act);
            end
         end
         bus.if_req   = pend[0].v;
         bus.if_addr  = pend[0].addr;
         bus.ls_req   = pend[1].v;
         bus.ls_we    = pend[1].we;
         bus.ls_addr  = pend[1].addr;
         bus.ls_wdata = pend[1].wdata;
         d = $urandom_range(0, 9) == 0 ? NEVER : int'($urandom_range(0, 3));
         mfc_dly = d;
         rd_word = $urandom;
         r0 = rd_cyc;
         w0 = wr_cyc;
         ew = pend[0].v && pend[1].v ? !m_last_ls : pend[1].v;
         w = 0;
         do begin step(); w++; end while (!(bus.if_gnt || bus.ls_gnt) && w < 6);
         chk($sformatf("r%0d gnt_wait", i), w, gw);
         chk($sformatf("r%0d winner", i), {bus.ls_gnt, bus.if_gnt}, ew ? 2'b10 : 2'b01);
         act = bus.ls_gnt;
         m_last_ls = ew;
         if (act) bus.ls_req = 1'b0;
         else bus.if_req = 1'b0;
         we  = pend[act].we;
         e   = exp_err(pend[act].addr, we);
         tmo = !e && d == NEVER;
         lat = e ? 1 : tmo ? TO : d + 1;
         er  = e || tmo || we ? 32'h0 : rd_word;
         if (!e) chk($sformatf("r%0d pmi_address", i), bus.pmi_address, pend[act].addr);
         w = 0;
         do begin step(); w++; end while (!(bus.if_rvalid || bus.ls_rvalid) && w < 40);
         chk($sformatf("r%0d rsp_latency", i), w, lat);
         chk($sformatf("r%0d rvalid_port", i), {bus.ls_rvalid, bus.if_rvalid}, act ? 2'b10 : 2'b01);
         chk($sformatf("r%0d rdata", i), act ? bus.ls_rdata : bus.if_rdata, er);
         chk($sformatf("r%0d err", i), act ? bus.ls_err : bus.if_err, e || tmo);
         chk($sformatf("r%0d rd_cycles", i), rd_cyc - r0, e || we ? 0 : lat);
         chk($sformatf("r%0d wr_cycles", i), wr_cyc - w0, !e && we ? lat : 0);
         pend[act].v = 1'b0;
         gw = 2;
      end
      mfc_noise = 1'b0;
      step();
      mfc_dly      = NEVER;
      bus.ls_req   = 1'b1;
      bus.ls_we    = 1'b0;
      bus.ls_addr  = 32'h0003_0100;
      w = 0;
      do begin step(); w++; end while (!bus.ls_gnt && w < 6);
      chk("abort gnt_wait", w, 1);
      bus.ls_req = 1'b0;
      repeat (3) step();
      chk("abort busy_rd", bus.pmi_mem_rd, 1);
      rst_n = 1'b0;
      #1;
      chk_reset("abort_async");
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0000_0040;
      bus.ls_req  = 1'b1;
      bus.ls_addr = 32'h0003_0200;
      mfc_dly     = 0;
      rd_word     = 32'h600D_F00D;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("abort quiet%0d", k), {bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid}, 0);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         if (bus.if_gnt || bus.ls_gnt) g.push_back(bus.ls_gnt);
         if (bus.if_rvalid || bus.ls_rvalid) begin
            r.push_back(bus.ls_rvalid);
            chk($sformatf("alt rdata%0d", k), bus.ls_rvalid ? bus.ls_rdata : bus.if_rdata, 32'h600D_F00D);
         end
      end
      bus.if_req = 1'b0;
      bus.ls_req = 1'b0;
      chk("alt gnt_count", g.size(), 4);
      chk("alt rvalid_count", r.size(), 4);
      for (int k = 0; k < 4 && k < g.size(); k++) chk($sformatf("alt gnt%0d_is_ls", k), g[k], k % 2 == 0);
      for (int k = 0; k < 4 && k < r.size(); k++) chk($sformatf("alt rvalid%0d_is_ls", k), r[k], k % 2 == 0);
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the physical memory interface (`pmi`). It shares the single memory port between the instruction-fetch unit (read-only) and the load/store unit (read/write). It latches the winning request, drives the memory read/write strobes until memory-function-complete (`mfc`) is sampled, and returns data or an error to the requester. It also decodes the system address map and applies a timeout so a missing `mfc` cannot hang the core.

## Interface
Parameters:
- `TIMEOUT`, 16 — max cycles in BUSY waiting for `mfc` before an error response (≥2).
- `CNT_W`, `$clog2(TIMEOUT+1)` — timeout counter width.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `if_req`  in  1  — fetch request; held with `if_addr` until `if_gnt`.
- `if_addr`  in  32  — fetch byte address.
- `if_gnt`  out  1  — one-cycle pulse: fetch request accepted.
- `if_rvalid`  out  1  — one-cycle pulse: fetch response valid.
- `if_rdata`  out  32  — fetch read data, valid with `if_rvalid`.
- `if_err`  out  1  — fetch error, valid with `if_rvalid`.
- `ls_req`  in  1  — load/store request; held with `ls_we`/`ls_addr`/`ls_wdata` until `ls_gnt`.
- `ls_we`  in  1  — 1 = write, 0 = read.
- `ls_addr`  in  32  — load/store byte address.
- `ls_wdata`  in  32  — store data.
- `ls_gnt`  out  1  — one-cycle pulse: load/store accepted.
- `ls_rvalid`  out  1  — one-cycle pulse: response (reads and writes).
- `ls_rdata`  out  32  — load data; 0 for writes and errors.
- `ls_err`  out  1  — load/store error, valid with `ls_rvalid`.
- `pmi_address`  out  32  — to `pmi.address`.
- `pmi_data_in`  out  32  — to `pmi.data_in`.
- `pmi_mem_rd`  out  1  — to `pmi.mem_rd`.
- `pmi_mem_wr`  out  1  — to `pmi.mem_wr`.
- `pmi_data`  in  32  — from `pmi.data`.
- `pmi_mfc`  in  1  — from `pmi.mfc`.

## Operation
- States: IDLE, BUSY, RESP. All outputs are registered.
- Arbitration happens in IDLE:
  - Only one `req` high: that requester wins.
  - Both high: round-robin using `last_ls`. If the previous grant was ls, fetch wins; otherwise ls wins. After reset, `last_ls`=0, so ls wins the first tie.
- Decode of the winning address:
  - Instruction region 0x0000_0000–0x0000_FFFF: read-only.
  - CSR region 0x0001_0000–0x0001_FFFF: read/write.
  - Reserved region 0x0002_0000–0x0002_FFFF: error.
  - Data region 0x0003_0000–0xDFFF_FFFF: read/write.
  - ≥0xE000_0000: error.
  - Error also for: any write to the instruction region; any access with `addr[1:0]`≠0.
- IDLE → BUSY (legal request):
  - `gnt` pulses for the winner.
  - Address and wdata are latched into `pmi_address`/`pmi_data_in`.
  - `pmi_mem_rd`=~we or `pmi_mem_wr`=we; fetch always uses rd.
  - Timeout counter is cleared.
- IDLE → RESP (decode error):
  - `gnt` pulses.
  - No strobe is issued.
  - `err`=1, `rdata`=0.
- BUSY, `pmi_mfc`=1 at an edge:
  - Strobes drop.
  - `rdata` ← `pmi_data` for reads, 0 for writes; `err`=0.
  - Go to RESP.
- BUSY, counter reaches TIMEOUT−1 without `mfc`:
  - Strobes drop.
  - `err`=1, `rdata`=0.
  - Go to RESP.
- RESP:
  - The owner's `rvalid` is high for one cycle.
  - Next state is IDLE.
  - A new request is arbitrated in the following IDLE cycle; there is no back-to-back grant from RESP.
- `pmi_address`/`pmi_data_in` hold their last values outside BUSY. Strobes are 0 outside BUSY.
- Requests that arrive while BUSY/RESP wait; they are neither dropped nor queued beyond the requester's hold.

## Timing
- Reset (async, `rst_n`=0):
  - State IDLE, `last_ls`=0, counter 0.
  - All outputs 0: `*_gnt`, `*_rvalid`, `*_rdata`, `*_err`, `pmi_*` strobes, `pmi_address`, `pmi_data_in`.
  - A reset mid-transaction aborts it: strobes fall immediately and no response is issued.
- Request sampled high at edge N (state IDLE):
  - `gnt` and strobes high in cycle N..N+1.
  - Earliest `mfc` sample at edge N+1.
  - `rvalid` in cycle N+1..N+2.
  - Minimum request-to-response latency: 2 cycles.
- Decode error: `rvalid` one cycle after `gnt`; latency 2 cycles.
- Timeout: strobes high for exactly TIMEOUT cycles, then `rvalid`+`err`.
- `pmi_mfc` is sampled only in BUSY; `mfc` in other states is ignored.
- Throughput: at most one transaction per 3 cycles.

## Test plan
- Fetch read at 0x0000_0010, `pmi_data`=0xDEADBEEF, `mfc` returned 1 cycle after the strobe → `if_gnt` pulse, `pmi_mem_rd` high 1 cycle, `if_rvalid` 2 cycles after request, `if_rdata`=0xDEADBEEF, `if_err`=0.
- `if_req` and `ls_req` both high continuously after reset, `mfc` immediate → grants alternate ls, if, ls, if; each response goes to the correct port only.
- ls write 0x1234_5678 to 0x0003_0000 → `pmi_mem_wr`=1, `pmi_data_in`=0x12345678, `pmi_mem_rd`=0, `ls_rvalid` with `ls_rdata`=0, `ls_err`=0.
- Decode errors: ls write to 0x0000_0100, ls read at 0x0002_0000, fetch at 0xE000_0000, ls read at 0x0003_0002 → each gives `gnt`, no strobe, `err`=1, `rdata`=0.
- `mfc` held 0 with TIMEOUT=16 → `pmi_mem_rd` high exactly 16 cycles, then `ls_rvalid`+`ls_err`=1; the next request is served normally.
- `rst_n` asserted while BUSY → all outputs 0 asynchronously, no `rvalid`; after release, a pending `ls_req` wins with `last_ls`=0.
